// File: rtl/lcd_frame_writer.sv
// HD44780 writer: power-up wait, init commands, then continuous two-line refresh of
// hex operand fields (line 1) and an operation mnemonic (line 2) with a blinking edit digit.
module lcd_frame_writer #(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned OPERANDS   = 2,
   parameter int unsigned E_CYCLES   = 12,
   parameter int unsigned CMD_WAIT   = 2000,
   parameter int unsigned CLEAR_WAIT = 82000,
   parameter int unsigned PWR_WAIT   = 750000,
   parameter int unsigned BLINK_DIV  = 12500000
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [OPERANDS*DIGITS*4-1:0]   op_data,
   input  logic [2:0]                     op_sel,
   input  logic                           edit_en,
   input  logic [1:0]                     edit_field,
   input  logic [2:0]                     edit_pos,
   output logic                           lcd_e,
   output logic                           lcd_rs,
   output logic                           lcd_rw,
   output logic [7:0]                     lcd_db,
   output logic                           ready,
   output logic                           frame_done
);

   localparam int unsigned NIBBLES = OPERANDS * DIGITS;
   localparam int unsigned DATA_W  = NIBBLES * 4;
   localparam int unsigned CMD_END = E_CYCLES + CMD_WAIT;
   localparam int unsigned CLR_END = E_CYCLES + CLEAR_WAIT;
   localparam int unsigned MAX_BC  = (CLR_END > CMD_END) ? CLR_END : CMD_END;
   localparam int unsigned MAX_CNT = (PWR_WAIT > MAX_BC) ? PWR_WAIT : MAX_BC;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1) + 1;
   localparam int unsigned BLK_W   = $clog2(BLINK_DIV + 1);

   typedef enum logic [2:0] {
      PWR, INIT, L1_ADDR, L1_CHAR, L2_ADDR, L2_CHAR, FRAME_END
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, byte_last;
   logic [3:0]         idx_q, idx_d;
   logic [1:0]         fld_q, fld_d;
   logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
   logic               blink_q, blink_d;
   logic [DATA_W-1:0]  snap_data_q, snap_data_d;
   logic [2:0]         snap_sel_q, snap_sel_d;
   logic               snap_edit_q, snap_edit_d;
   logic [1:0]         snap_field_q, snap_field_d;
   logic [2:0]         snap_pos_q, snap_pos_d;
   logic               snap_blink_q, snap_blink_d;
   logic               lcd_e_q, lcd_e_d;
   logic               lcd_rs_q, lcd_rs_d;
   logic [7:0]         lcd_db_q, lcd_db_d;
   logic               ready_q, ready_d;
   logic               frame_done_q, frame_done_d;
   logic               load;
   int unsigned        nib_sel;
   logic [3:0]         nibble;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      logic [7:0] c;
      c = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
      return c;
   endfunction

   function automatic logic [7:0] init_cmd(input logic [3:0] pos);
      logic [7:0] c;
      case (pos)
         4'd0:    c = 8'h38;
         4'd1:    c = 8'h0C;
         4'd2:    c = 8'h06;
         default: c = 8'h01;
      endcase
      return c;
   endfunction

   function automatic logic [7:0] mnem_char(input logic [2:0] sel, input logic [3:0] pos);
      logic [23:0] s;
      logic [7:0]  c;
      case (sel)
         3'd0:    s = "ADD";
         3'd1:    s = "SUB";
         3'd2:    s = "AND";
         3'd3:    s = "OR ";
         3'd4:    s = "XOR";
         default: s = 24'h202020;
      endcase
      case (pos)
         4'd0:    c = s[23:16];
         4'd1:    c = s[15:8];
         default: c = s[7:0];
      endcase
      return c;
   endfunction

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      fld_d        = fld_q;
      snap_data_d  = snap_data_q;
      snap_sel_d   = snap_sel_q;
      snap_edit_d  = snap_edit_q;
      snap_field_d = snap_field_q;
      snap_pos_d   = snap_pos_q;
      snap_blink_d = snap_blink_q;
      lcd_e_d      = lcd_e_q;
      lcd_rs_d     = lcd_rs_q;
      lcd_db_d     = lcd_db_q;
      ready_d      = ready_q;
      frame_done_d = 1'b0;
      load         = 1'b0;
      nib_sel      = 0;
      nibble       = '0;
      byte_last    = (state_q == INIT && idx_q == 4'd3) ? CNT_W'(CLR_END) : CNT_W'(CMD_END);

      if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
         blink_cnt_d = '0;
         blink_d     = ~blink_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
         blink_d     = blink_q;
      end

      case (state_q)
         PWR: begin
            if (cnt_q == CNT_W'(PWR_WAIT)) begin
               state_d = INIT;
               idx_d   = '0;
               load    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FRAME_END: begin
            state_d = L1_ADDR;
            load    = 1'b1;
         end
         default: begin
            // Frame content is frozen at the edge that raises lcd_e for the 8'h80 write.
            if (state_q == L1_ADDR && cnt_q == '0) begin
               snap_data_d  = op_data;
               snap_sel_d   = op_sel;
               snap_edit_d  = edit_en;
               snap_field_d = edit_field;
               snap_pos_d   = edit_pos;
               snap_blink_d = blink_q;
            end
            if (cnt_q != byte_last) begin
               cnt_d   = cnt_q + 1'b1;
               lcd_e_d = (cnt_q < CNT_W'(E_CYCLES));
            end else begin
               cnt_d = '0;
               load  = 1'b1;
               case (state_q)
                  INIT: begin
                     if (idx_q == 4'd3) begin
                        state_d = L1_ADDR;
                        ready_d = 1'b1;
                     end else begin
                        idx_d = idx_q + 1'b1;
                     end
                  end
                  L1_ADDR: begin
                     state_d = L1_CHAR;
                     idx_d   = '0;
                     fld_d   = '0;
                  end
                  L1_CHAR: begin
                     // idx == DIGITS is the blank between two fields.
                     if (idx_q == 4'(DIGITS)) begin
                        fld_d = fld_q + 1'b1;
                        idx_d = '0;
                     end else if (idx_q == 4'(DIGITS - 1)) begin
                        if (fld_q == 2'(OPERANDS - 1)) state_d = L2_ADDR;
                        else                           idx_d   = 4'(DIGITS);
                     end else begin
                        idx_d = idx_q + 1'b1;
                     end
                  end
                  L2_ADDR: begin
                     state_d = L2_CHAR;
                     idx_d   = '0;
                  end
                  L2_CHAR: begin
                     if (idx_q == 4'd2) begin
                        state_d      = FRAME_END;
                        frame_done_d = 1'b1;
                        load         = 1'b0;
                     end else begin
                        idx_d = idx_q + 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase

      if (load) begin
         cnt_d   = '0;
         lcd_e_d = 1'b0;
         case (state_d)
            INIT: begin
               lcd_rs_d = 1'b0;
               lcd_db_d = init_cmd(idx_d);
            end
            L1_ADDR: begin
               lcd_rs_d = 1'b0;
               lcd_db_d = 8'h80;
            end
            L1_CHAR: begin
               // Field 0 digit 0 sits in the most significant nibble of op_data.
               lcd_rs_d = 1'b1;
               nib_sel  = NIBBLES - 1 - (32'(fld_d) * DIGITS + 32'(idx_d));
               nibble   = 4'(snap_data_q >> (nib_sel * 4));
               if (idx_d == 4'(DIGITS))
                  lcd_db_d = 8'h20;
               else if (snap_edit_q && snap_blink_q && fld_d == snap_field_q &&
                        idx_d == {1'b0, snap_pos_q})
                  lcd_db_d = 8'h20;
               else
                  lcd_db_d = hex_char(nibble);
            end
            L2_ADDR: begin
               lcd_rs_d = 1'b0;
               lcd_db_d = 8'hC0;
            end
            L2_CHAR: begin
               lcd_rs_d = 1'b1;
               lcd_db_d = mnem_char(snap_sel_q, idx_d);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= PWR;
         cnt_q        <= '0;
         idx_q        <= '0;
         fld_q        <= '0;
         blink_cnt_q  <= '0;
         blink_q      <= 1'b0;
         snap_data_q  <= '0;
         snap_sel_q   <= '0;
         snap_edit_q  <= 1'b0;
         snap_field_q <= '0;
         snap_pos_q   <= '0;
         snap_blink_q <= 1'b0;
         lcd_e_q      <= 1'b0;
         lcd_rs_q     <= 1'b0;
         lcd_db_q     <= 8'h00;
         ready_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         fld_q        <= fld_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_q      <= blink_d;
         snap_data_q  <= snap_data_d;
         snap_sel_q   <= snap_sel_d;
         snap_edit_q  <= snap_edit_d;
         snap_field_q <= snap_field_d;
         snap_pos_q   <= snap_pos_d;
         snap_blink_q <= snap_blink_d;
         lcd_e_q      <= lcd_e_d;
         lcd_rs_q     <= lcd_rs_d;
         lcd_db_q     <= lcd_db_d;
         ready_q      <= ready_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign lcd_e      = lcd_e_q;
   assign lcd_rs     = lcd_rs_q;
   assign lcd_rw     = 1'b0;
   assign lcd_db     = lcd_db_q;
   assign ready      = ready_q;
   assign frame_done = frame_done_q;

endmodule
